mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum cycles to wait for mem_ack_i before a transaction is aborted.
REQ-002 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_i  input  1  asynchronous, active-low reset.
REQ-004 if_req_i  input  1  instruction-fetch request, level, held until if_ack_o.
REQ-005 if_addr_i  input  32  fetch address.
REQ-006 if_ack_o  output  1  one-cycle pulse: fetch complete.
REQ-007 if_data_o  output  32  fetched word, held until next if_ack_o.
REQ-008 dm_req_i  input  1  data-memory request, level, held until dm_ack_o.
REQ-009 dm_we_i  input  1  1 = write, 0 = read.
REQ-010 dm_addr_i  input  32  data address.
REQ-011 dm_wdata_i  input  32  write data.
REQ-012 dm_ack_o  output  1  one-cycle pulse: data access complete.
REQ-013 dm_rdata_o  output  32  read word, held until next read dm_ack_o.
REQ-014 mem_en_o  output  1  shared-memory transaction active.
REQ-015 mem_we_o  output  1  shared-memory write strobe.
REQ-016 mem_addr_o  output  32  shared-memory address.
REQ-017 mem_wdata_o  output  32  shared-memory write data.
REQ-018 mem_rdata_i  input  32  shared-memory read data, valid when mem_ack_i = 1.
REQ-019 mem_ack_i  input  1  shared memory done, may arrive 1..any cycles after mem_en_o rises.
REQ-020 stall_o  output  1  pipeline freeze request.
REQ-021 timeout_o  output  1  sticky error flag.

Function
REQ-022 FSM states: IDLE, IF_BUSY, DM_BUSY.
REQ-023 IDLE to DM_BUSY when dm_req_i = 1; otherwise to IF_BUSY when if_req_i = 1. Fixed priority: data over fetch.
REQ-024 On grant, register addr, we and wdata from the granted port; mem_* outputs come from these registers, stable for the whole transaction.
REQ-025 mem_en_o = 1 exactly in the BUSY states; mem_we_o = 1 only in DM_BUSY with a registered write.
REQ-026 On mem_ack_i = 1 in a BUSY state:
  - next cycle, the granted port's ack_o = 1 for exactly one cycle;
  - read data is captured into if_data_o or dm_rdata_o;
  - a write leaves dm_rdata_o unchanged;
  - the FSM returns to IDLE.
REQ-027 In the cycle a port's ack_o = 1, that port's req_i is ignored for arbitration. Minimum spacing between two grants to one port: 2 cycles.
REQ-028 mem_ack_i in IDLE is ignored.
REQ-029 stall_o = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o), combinational.
REQ-030 Wait counter clears on grant and increments every BUSY cycle without mem_ack_i. When it reaches TIMEOUT:
  - the port is acked with data 0;
  - timeout_o is set;
  - the FSM returns to IDLE.
REQ-031 mem_ack_i in the same cycle the count reaches TIMEOUT counts as a normal completion; no timeout.
REQ-032 timeout_o clears only on reset.

Reset
REQ-033 Asynchronous assertion sets: state IDLE; all acks, mem_en_o, mem_we_o and timeout_o 0; mem_addr_o, mem_wdata_o, if_data_o and dm_rdata_o 0; counter 0.
REQ-034 Reset mid-transaction discards the transaction; no ack follows.
REQ-035 The first grant is possible on the first rising edge after deassertion.

Structure
REQ-036 Shared package mem_arb_pkg holds the state enum, ADDR_W = 32, DATA_W = 32 and the TIMEOUT default.
REQ-037 The wait counter and compare logic form one sub-module, mem_arb_timer (inputs clear/enable; output expired).

Verification
REQ-038 Fetch alone: if_req_i = 1, if_addr_i = 0x40, mem_ack_i 2 cycles after mem_en_o with data 0x8C010004 -> if_ack_o pulses once; if_data_o = 0x8C010004; mem_we_o = 0 throughout.
REQ-039 Same-cycle requests: fetch 0x44 and data read 0x100 -> dm granted first (mem_addr_o = 0x100); fetch granted in the cycle after dm_ack_o; stall_o high until if_ack_o.
REQ-040 Write: dm_we_i = 1, addr 0x10, wdata 0xDEADBEEF -> mem_we_o = 1 and mem_wdata_o = 0xDEADBEEF until ack; dm_rdata_o keeps its prior value.
REQ-041 Timeout: TIMEOUT = 16, mem_ack_i never asserted -> ack with data 0 after 16 BUSY cycles; timeout_o = 1 and stays 1 through later transactions.
REQ-042 Reset in DM_BUSY: rst_i low mid-transaction -> all outputs 0 immediately; no dm_ack_o after release; a re-raised dm_req_i completes normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and sizing for the instruction/data memory arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    IF_BUSY,
    DM_BUSY
  } arb_state_e;

endpackage

// File: rtl/mem_arb_timer.sv
// Wait-cycle counter for a shared-memory transaction; flags the cycle the limit is hit.
module mem_arb_timer
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned      CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (enable_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Fires during the waiting cycle whose increment would bring the count to TIMEOUT.
  assign expired_o = enable_i && (cnt_q == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Fixed-priority arbiter sharing one memory port between fetch and data access.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [DATA_W-1:0] if_data_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_ack_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              stall_o,
  output logic              timeout_o
);

  arb_state_e        state_q, state_d;
  logic              grant_if, grant_dm, done, expired, busy;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, resp_data;

  assign busy      = (state_q != IDLE);
  assign resp_data = expired ? '0 : mem_rdata_i;

  mem_arb_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (grant_if | grant_dm),
    .enable_i (busy & ~mem_ack_i),
    .expired_o(expired)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A port still showing its ack this cycle is not eligible, so held requests are not re-granted.
  always_comb begin
    state_d  = state_q;
    grant_if = 1'b0;
    grant_dm = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dm_req_i && !dm_ack_o) begin
          state_d  = DM_BUSY;
          grant_dm = 1'b1;
        end else if (if_req_i && !if_ack_o) begin
          state_d  = IF_BUSY;
          grant_if = 1'b1;
        end
      end
      IF_BUSY, DM_BUSY: begin
        if (mem_ack_i || expired) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      if_ack_o   <= 1'b0;
      dm_ack_o   <= 1'b0;
      if_data_o  <= '0;
      dm_rdata_o <= '0;
      timeout_o  <= 1'b0;
    end else begin
      if_ack_o <= 1'b0;
      dm_ack_o <= 1'b0;
      if (grant_dm) begin
        addr_q  <= dm_addr_i;
        we_q    <= dm_we_i;
        wdata_q <= dm_wdata_i;
      end else if (grant_if) begin
        addr_q  <= if_addr_i;
        we_q    <= 1'b0;
        wdata_q <= '0;
      end
      if (done) begin
        if (state_q == IF_BUSY) begin
          if_ack_o  <= 1'b1;
          if_data_o <= resp_data;
        end else begin
          dm_ack_o <= 1'b1;
          if (!we_q) begin
            dm_rdata_o <= resp_data;
          end
        end
      end
      if (expired) begin
        timeout_o <= 1'b1;
      end
    end
  end

  assign mem_en_o    = busy;
  assign mem_we_o    = (state_q == DM_BUSY) && we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign stall_o     = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a transaction-level model.
module tb_mem_arbiter;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        if_req_i, dm_req_i, dm_we_i, mem_ack_i;
  logic [31:0] if_addr_i, dm_addr_i, dm_wdata_i, mem_rdata_i;
  logic        if_ack_o, dm_ack_o, mem_en_o, mem_we_o, stall_o, timeout_o;
  logic [31:0] if_data_o, dm_rdata_o, mem_addr_o, mem_wdata_o;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ack_o(if_ack_o), .if_data_o(if_data_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_ack_o(dm_ack_o), .dm_rdata_o(dm_rdata_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .stall_o(stall_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference: one in-flight transaction record plus the visible port results.
  logic        m_busy, m_port_dm, m_we, m_if_ack, m_dm_ack, m_tmo;
  logic [31:0] m_addr, m_wdata, m_if_data, m_dm_rdata;
  int          m_elapsed;
  int          if_ack_cnt;

  // Memory responder controls.
  bit          rand_mode = 1'b0;
  int          mem_lat   = 1;
  int          next_lat  = 1;
  logic [31:0] rd_val    = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_port_dm = 0; m_we = 0; m_if_ack = 0; m_dm_ack = 0; m_tmo = 0;
    m_addr = '0; m_wdata = '0; m_if_data = '0; m_dm_rdata = '0; m_elapsed = 0;
  endtask

  function automatic int pick_lat();
    int r;
    if (!rand_mode) return next_lat;
    r = int'($urandom_range(0, 9));
    if (r < 7) return int'($urandom_range(1, 4));
    if (r < 9) return int'($urandom_range(5, TO));
    return int'($urandom_range(TO + 1, TO + 3));
  endfunction

  // Advance the reference by one rising edge using the inputs present at that edge.
  task automatic model_update();
    logic        pa_if, pa_dm, fin;
    logic [31:0] d;
    pa_if = m_if_ack; pa_dm = m_dm_ack;
    m_if_ack = 0; m_dm_ack = 0;
    fin = 0; d = '0;
    if (m_busy) begin
      if (mem_ack_i) begin
        fin = 1; d = mem_rdata_i;
      end else if (m_elapsed + 1 == int'(TO)) begin
        fin = 1; d = '0; m_tmo = 1;
      end else begin
        m_elapsed++;
      end
      if (fin) begin
        m_busy = 0;
        if (m_port_dm) begin
          m_dm_ack = 1;
          if (!m_we) m_dm_rdata = d;
        end else begin
          m_if_ack = 1;
          m_if_data = d;
        end
      end
    end else if (dm_req_i && !pa_dm) begin
      m_busy = 1; m_port_dm = 1; m_we = dm_we_i; m_addr = dm_addr_i; m_wdata = dm_wdata_i;
      m_elapsed = 0; mem_lat = pick_lat();
    end else if (if_req_i && !pa_if) begin
      m_busy = 1; m_port_dm = 0; m_we = 0; m_addr = if_addr_i;
      m_elapsed = 0; mem_lat = pick_lat();
    end
  endtask

  task automatic compare_all();
    chk("if_ack", 32'(if_ack_o), 32'(m_if_ack));
    chk("dm_ack", 32'(dm_ack_o), 32'(m_dm_ack));
    chk("if_data", if_data_o, m_if_data);
    chk("dm_rdata", dm_rdata_o, m_dm_rdata);
    chk("mem_en", 32'(mem_en_o), 32'(m_busy));
    chk("mem_we", 32'(mem_we_o), 32'(m_busy & m_port_dm & m_we));
    chk("timeout", 32'(timeout_o), 32'(m_tmo));
    if (m_busy) begin
      chk("mem_addr", mem_addr_o, m_addr);
      if (m_port_dm && m_we) chk("mem_wdata", mem_wdata_o, m_wdata);
    end
  endtask

  task automatic drive_mem();
    if (rand_mode) rd_val = $urandom;
    mem_rdata_i = rd_val;
    if (m_busy) mem_ack_i = (m_elapsed + 1 == mem_lat);
    else        mem_ack_i = rand_mode && ($urandom_range(0, 3) == 0);
  endtask

  task automatic step();
    #1;
    chk("stall", 32'(stall_o), 32'((if_req_i & ~m_if_ack) | (dm_req_i & ~m_dm_ack)));
    @(posedge clk);
    #1;
    model_update();
    compare_all();
    if (if_ack_o) if_ack_cnt++;
  endtask

  task automatic run_until_idle(input int max);
    int n = 0;
    do begin
      step();
      if (m_if_ack) if_req_i = 0;
      if (m_dm_ack) dm_req_i = 0;
      drive_mem();
      n++;
    end while ((m_busy || if_req_i || dm_req_i) && n < max);
    chk("drain_bound", 32'(m_busy | if_req_i | dm_req_i), 32'(0));
  endtask

  task automatic rand_reqs();
    if (m_if_ack || !if_req_i) begin
      if_req_i  = ($urandom_range(0, 99) < 40);
      if_addr_i = $urandom;
    end
    if (m_dm_ack || !dm_req_i) begin
      dm_req_i   = ($urandom_range(0, 99) < 40);
      dm_we_i    = $urandom_range(0, 1) == 1;
      dm_addr_i  = $urandom;
      dm_wdata_i = $urandom;
    end
    drive_mem();
  endtask

  initial begin
    rst_i = 0; if_req_i = 0; dm_req_i = 0; dm_we_i = 0; mem_ack_i = 0;
    if_addr_i = '0; dm_addr_i = '0; dm_wdata_i = '0; mem_rdata_i = '0;
    if_ack_cnt = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();

    // Fetch alone, first grant on the first edge after reset release.
    rst_i = 1;
    if_req_i = 1; if_addr_i = 32'h40; next_lat = 2; rd_val = 32'h8C010004;
    drive_mem();
    run_until_idle(20);
    chk("fetch_data", if_data_o, 32'h8C010004);
    chk("fetch_acks", 32'(if_ack_cnt), 32'(1));

    // Same-cycle fetch and data read: data wins.
    if_req_i = 1; if_addr_i = 32'h44;
    dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h100;
    next_lat = 3; rd_val = 32'h1111_2222;
    drive_mem();
    run_until_idle(30);

    // Write leaves read data untouched.
    dm_req_i = 1; dm_we_i = 1; dm_addr_i = 32'h10; dm_wdata_i = 32'hDEADBEEF;
    next_lat = 3; rd_val = 32'h5555_AAAA;
    drive_mem();
    run_until_idle(20);
    chk("write_keeps_rdata", dm_rdata_o, 32'h1111_2222);

    // Ack on the limit cycle is a normal completion.
    dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h20; next_lat = int'(TO); rd_val = 32'hA5A5_5A5A;
    drive_mem();
    run_until_idle(40);
    chk("limit_no_timeout", 32'(timeout_o), 32'(0));

    // Memory never answers.
    dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h200; next_lat = 1000;
    drive_mem();
    run_until_idle(40);
    chk("timeout_flag", 32'(timeout_o), 32'(1));
    chk("timeout_data", dm_rdata_o, 32'h0);
    if_req_i = 1; if_addr_i = 32'h48; next_lat = 1; rd_val = 32'h0BAD_F00D;
    drive_mem();
    run_until_idle(20);

    // Reset while a data access is outstanding.
    dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h300; next_lat = 1000;
    drive_mem();
    repeat (3) step();
    rst_i = 0; dm_req_i = 0; mem_ack_i = 0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    rst_i = 1;
    repeat (3) step();
    dm_req_i = 1; next_lat = 2; rd_val = 32'hCAFE_0001;
    drive_mem();
    run_until_idle(20);
    chk("post_reset_rdata", dm_rdata_o, 32'hCAFE_0001);

    // Randomized traffic with random latencies and stray idle acks.
    rand_mode = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      rand_reqs();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
